// File: rtl/stream_dmux_pkg.sv
// Shared types and defaults for the registered N-way stream demultiplexer.
// Provides default sizes, the select-width helper and the slot state enum.
package stream_dmux_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 4;

  // Select width for n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/stream_dmux_n_slot.sv
// One-entry output register slot with valid/ready and same-cycle refill.
// Ports: clk, reset, wr_en, wr_data, out_ready, out_valid, out_data, free.
module dmux_slot
  import stream_dmux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             free
);

  slot_state_e state;
  slot_state_e state_nx;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // A write while draining keeps the slot full with no bubble.
  always_comb begin
    state_nx = state;
    case (state)
      SLOT_EMPTY: begin
        if (wr_en) state_nx = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (wr_en)          state_nx = SLOT_FULL;
        else if (out_ready) state_nx = SLOT_EMPTY;
      end
      default: state_nx = SLOT_EMPTY;
    endcase
  end

  // Data only moves on a write, so it is stable under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (wr_en) begin
      data_q <= wr_data;
    end
  end

  always_comb begin
    out_valid = (state == SLOT_FULL);
    out_data  = data_q;
    free      = (state == SLOT_EMPTY) | out_ready;
  end

endmodule

// File: rtl/stream_dmux_n.sv
// Registered 1-to-N valid/ready stream demultiplexer, one slot per channel.
// Ports: clk, reset, in_valid/in_ready/in_data/in_sel, out_valid/out_ready/
// out_data (channel k at [k*WIDTH +: WIDTH]), sel_err pulse on dropped word.
// Option STREAM_DMUX_BROADCAST_EN adds in_bcast: write the word to all slots.
module stream_dmux_n
  import stream_dmux_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
`ifdef STREAM_DMUX_BROADCAST_EN
  input  logic                      in_bcast,
`endif
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      sel_err
);

  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] wr_en;
  logic                sel_ok;
  logic                sel_ready;
  logic                bcast;
  logic                accept;

`ifdef STREAM_DMUX_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // One-hot decode; an out-of-range select matches no channel.
  always_comb begin
    hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      hit[k] = (in_sel == SEL_W'(k));
    end
  end

  // in_ready never looks at in_valid; dropped words are always taken.
  always_comb begin
    sel_ok    = |hit;
    sel_ready = (|(hit & free)) | ~sel_ok;
    in_ready  = bcast ? (&free) : sel_ready;
    accept    = in_valid & in_ready;
    wr_en     = {CHANNELS{accept}} & (hit | {CHANNELS{bcast}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= accept & ~bcast & ~sel_ok;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
    dmux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[g]),
      .wr_data  (in_data),
      .out_ready(out_ready[g]),
      .out_valid(out_valid[g]),
      .out_data (out_data[g*WIDTH +: WIDTH]),
      .free     (free[g])
    );
  end

endmodule

// File: tb/tb_stream_dmux_n.sv
// Self-checking bench for stream_dmux_n: directed scenarios plus random
// traffic against an array-based model of the per-channel slots.
module tb_stream_dmux_n;

  logic        clk;
  logic        reset;

  logic        iv;
  logic        ir;
  logic [15:0] idat;
  logic [1:0]  isel;
  logic        bc;
  logic [3:0]  ov;
  logic [3:0]  ordy;
  logic [63:0] od;
  logic        err;

  logic        iv3;
  logic        ir3;
  logic [15:0] idat3;
  logic [1:0]  isel3;
  logic [2:0]  ov3;
  logic [2:0]  ordy3;
  logic [47:0] od3;
  logic        err3;

  int pass_cnt;
  int total_cnt;

  bit          mv [4];
  logic [15:0] md [4];
  bit          m_err;

  stream_dmux_n #(.WIDTH(16), .CHANNELS(4)) u4 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (iv),
    .in_ready (ir),
    .in_data  (idat),
    .in_sel   (isel),
`ifdef STREAM_DMUX_BROADCAST_EN
    .in_bcast (bc),
`endif
    .out_valid(ov),
    .out_ready(ordy),
    .out_data (od),
    .sel_err  (err)
  );

  stream_dmux_n #(.WIDTH(16), .CHANNELS(3)) u3 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (iv3),
    .in_ready (ir3),
    .in_data  (idat3),
    .in_sel   (isel3),
`ifdef STREAM_DMUX_BROADCAST_EN
    .in_bcast (1'b0),
`endif
    .out_valid(ov3),
    .out_ready(ordy3),
    .out_data (od3),
    .sel_err  (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_ready();
    bit r;
    if (bc) begin
      r = 1'b1;
      for (int k = 0; k < 4; k++) r &= (!mv[k] || ordy[k]);
    end else if (int'(isel) >= 4) begin
      r = 1'b1;
    end else begin
      r = !mv[isel] || ordy[isel];
    end
    return r;
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = mv[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [15:0] d,
                       input logic [1:0] s, input logic [3:0] r,
                       input bit b);
    iv   = v;
    idat = d;
    isel = s;
    ordy = r;
    bc   = b;
  endtask

  // Advance one clock and apply the slot rules to the model.
  task automatic tick();
    bit          acc;
    bit          nv [4];
    logic [15:0] nd [4];
    bit          ne;
    acc = iv && model_ready();
    for (int k = 0; k < 4; k++) begin
      nv[k] = mv[k];
      nd[k] = md[k];
      if (acc && (bc || int'(isel) == k)) begin
        nv[k] = 1'b1;
        nd[k] = idat;
      end else if (mv[k] && ordy[k]) begin
        nv[k] = 1'b0;
      end
    end
    ne = acc && !bc && int'(isel) >= 4;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      mv[k] = nv[k];
      md[k] = nd[k];
    end
    m_err = ne;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 16'h0, 2'd0, 4'b0000, 0);
    iv3 = 0; idat3 = '0; isel3 = '0; ordy3 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (ov !== 4'b0000 || od !== 64'h0 || err !== 1'b0 || ir !== 1'b1)
      $display("FAIL reset_state: ov=%b od=%h err=%b ir=%b want 0000/0/0/1",
               ov, od, err, ir);
    else pass_cnt++;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    drive(1, 16'h1234, 2'd2, 4'b0000, 0);
    #1;
    total_cnt++;
    if (ir !== 1'b1) $display("FAIL reset_first_ready: ir=%b want 1", ir);
    else pass_cnt++;
    tick();
    drive(0, 16'h0, 2'd0, 4'b0000, 0);
    total_cnt++;
    if (ov !== 4'b0100 || od[47:32] !== 16'h1234)
      $display("FAIL reset_first_word: ov=%b d2=%h want 0100/1234",
               ov, od[47:32]);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    drive(1, 16'h00AA, 2'd1, 4'b0000, 0);
    #1;
    total_cnt++;
    if (ir !== 1'b1) $display("FAIL bp_first_ready: ir=%b want 1", ir);
    else pass_cnt++;
    tick();
    drive(1, 16'h00BB, 2'd1, 4'b0000, 0);
    #1;
    total_cnt++;
    if (ir !== 1'b0) $display("FAIL bp_second_ready: ir=%b want 0", ir);
    else pass_cnt++;
    tick();
    drive(1, 16'h00CC, 2'd3, 4'b0000, 0);
    #1;
    total_cnt++;
    if (ir !== 1'b1) $display("FAIL bp_sel3_ready: ir=%b want 1", ir);
    else pass_cnt++;
    tick();
    drive(0, 16'h0, 2'd0, 4'b0000, 0);
    total_cnt++;
    if (ov !== model_valid() || od[31:16] !== 16'h00AA ||
        od[63:48] !== 16'h00CC || md[1] !== 16'h00AA)
      $display("FAIL bp_hold: ov=%b d1=%h d3=%h want %b/00aa/00cc",
               ov, od[31:16], od[63:48], model_valid());
    else pass_cnt++;
  endtask

  task automatic test_full_rate();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 16'(i), 2'd0, 4'b0001, 0);
      #1;
      total_cnt++;
      if (ir !== 1'b1) $display("FAIL rate_ready_%0d: ir=%b want 1", i, ir);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ov[0] !== 1'b1 || od[15:0] !== 16'(i))
        $display("FAIL rate_word_%0d: v=%b d=%h want 1/%h",
                 i, ov[0], od[15:0], 16'(i));
      else pass_cnt++;
    end
    drive(0, 16'h0, 2'd0, 4'b0001, 0);
    tick();
    total_cnt++;
    if (ov[0] !== 1'b0) $display("FAIL rate_drain: v=%b want 0", ov[0]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 3) != 0), 16'($urandom),
            2'($urandom_range(0, 3)), 4'($urandom), 0);
      #1;
      total_cnt++;
      if (ir !== model_ready())
        $display("FAIL rand_ready_%0d: ir=%b want %b", n, ir, model_ready());
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ov !== model_valid() || err !== m_err)
        $display("FAIL rand_valid_%0d: ov=%b err=%b want %b/%b",
                 n, ov, err, model_valid(), m_err);
      else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
        if (mv[k]) begin
          total_cnt++;
          if (od[k*16 +: 16] !== md[k])
            $display("FAIL rand_data_%0d_ch%0d: d=%h want %h",
                     n, k, od[k*16 +: 16], md[k]);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 16'h0, 2'd0, 4'b1111, 0);
    tick();
    drive(1, 16'h0101, 2'd0, 4'b0000, 0);
    tick();
    drive(1, 16'h0303, 2'd3, 4'b0000, 0);
    tick();
    drive(0, 16'h0, 2'd0, 4'b0000, 0);
    total_cnt++;
    if (ov !== 4'b1001) $display("FAIL mid_fill: ov=%b want 1001", ov);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_clear();
    total_cnt++;
    if (ov !== 4'b0000 || od !== 64'h0)
      $display("FAIL mid_async_clear: ov=%b od=%h want 0000/0", ov, od);
    else pass_cnt++;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (ov !== 4'b0000 || err !== 1'b0)
      $display("FAIL mid_after: ov=%b err=%b want 0000/0", ov, err);
    else pass_cnt++;
  endtask

  task automatic test_sel_err();
    iv3 = 1; idat3 = 16'hDEAD; isel3 = 2'd3; ordy3 = 3'b000;
    #1;
    total_cnt++;
    if (ir3 !== 1'b1) $display("FAIL oor_ready: ir=%b want 1", ir3);
    else pass_cnt++;
    @(posedge clk);
    #1;
    iv3 = 0;
    total_cnt++;
    if (err3 !== 1'b1 || ov3 !== 3'b000)
      $display("FAIL oor_pulse: err=%b ov=%b want 1/000", err3, ov3);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (err3 !== 1'b0) $display("FAIL oor_one_cycle: err=%b want 0", err3);
    else pass_cnt++;
    iv3 = 1; idat3 = 16'h0B0B; isel3 = 2'd2;
    @(posedge clk);
    #1;
    iv3 = 0;
    total_cnt++;
    if (ov3 !== 3'b100 || od3[47:32] !== 16'h0B0B || err3 !== 1'b0)
      $display("FAIL oor_inrange: ov=%b d2=%h err=%b want 100/0b0b/0",
               ov3, od3[47:32], err3);
    else pass_cnt++;
  endtask

`ifdef STREAM_DMUX_BROADCAST_EN
  task automatic test_broadcast();
    drive(0, 16'h0, 2'd0, 4'b1111, 0);
    tick();
    drive(1, 16'h2222, 2'd2, 4'b1011, 0);
    tick();
    drive(1, 16'h5555, 2'd1, 4'b1011, 1);
    #1;
    total_cnt++;
    if (ir !== 1'b0) $display("FAIL bc_stall: ir=%b want 0", ir);
    else pass_cnt++;
    tick();
    #1;
    total_cnt++;
    if (ir !== 1'b0 || ov !== 4'b0100)
      $display("FAIL bc_stall2: ir=%b ov=%b want 0/0100", ir, ov);
    else pass_cnt++;
    ordy = 4'b1111;
    #1;
    total_cnt++;
    if (ir !== 1'b1) $display("FAIL bc_release: ir=%b want 1", ir);
    else pass_cnt++;
    tick();
    drive(0, 16'h0, 2'd0, 4'b0000, 0);
    total_cnt++;
    if (ov !== 4'b1111 || od !== {4{16'h5555}} || err !== 1'b0)
      $display("FAIL bc_all: ov=%b od=%h err=%b want 1111/5555x4/0",
               ov, od, err);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_backpressure();
    test_full_rate();
    test_random();
    test_reset_mid();
    test_sel_err();
`ifdef STREAM_DMUX_BROADCAST_EN
    test_broadcast();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
